// File: rtl/dma_if_mch.sv
// dma_if_mch: multi-channel DMA front end for a single AHB master control port.
//   Channels post transfer descriptors with Start; a round-robin arbiter picks
//   one pending channel at a time while the control FSM is idle and drives its
//   beats (Request/Addr/Size/Write/Burst/Beat). Grant advances the beat
//   address, Retry rewinds one beat, Error aborts with Done+ErrDone, and a
//   zero-length descriptor completes without touching the bus.
// Ports:
//   CLK, RST_N                       clock, async active-low reset
//   Start/WR/WRAddr/WRLen/WRSize/
//   WRBurst/Din/DmaLock              per-channel descriptor, write data, lock
//   ReadEn/DoutVld/Done/ErrDone/
//   ChBusy                           per-channel handshakes and status
//   Dout                             read data shared by all channels
//   Lock/Busy                        bus lock, any channel pending or active
//   Request/Addr/Size/Write/Burst/
//   Beat/DataIn                      master control port
//   DataOut/DataReady/Grant/Okay/
//   Error/Retry                      master responses
// Optional feature: define DMA_IF_MCH_TIMEOUT_EN to add parameter TO_CYC and
//   abort (Done+ErrDone) when END waits TO_CYC cycles for a response.
module dma_if_mch #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned LW     = 10
`ifdef DMA_IF_MCH_TIMEOUT_EN
  , parameter int unsigned TO_CYC = 255
`endif
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [NUM_CH-1:0]    Start,
  input  logic [NUM_CH-1:0]    WR,
  input  logic [NUM_CH*AW-1:0] WRAddr,
  input  logic [NUM_CH*LW-1:0] WRLen,
  input  logic [NUM_CH*3-1:0]  WRSize,
  input  logic [NUM_CH-1:0]    WRBurst,
  input  logic [NUM_CH*DW-1:0] Din,
  input  logic [NUM_CH-1:0]    DmaLock,
  output logic [NUM_CH-1:0]    ReadEn,
  output logic [NUM_CH-1:0]    DoutVld,
  output logic [DW-1:0]        Dout,
  output logic [NUM_CH-1:0]    Done,
  output logic [NUM_CH-1:0]    ErrDone,
  output logic [NUM_CH-1:0]    ChBusy,
  output logic                 Lock,
  output logic                 Busy,
  output logic                 Request,
  output logic [AW-1:0]        Addr,
  output logic [2:0]           Size,
  output logic                 Write,
  output logic                 Burst,
  output logic [2:0]           Beat,
  output logic [DW-1:0]        DataIn,
  input  logic [DW-1:0]        DataOut,
  input  logic                 DataReady,
  input  logic                 Grant,
  input  logic                 Okay,
  input  logic                 Error,
  input  logic                 Retry
);

  localparam int unsigned IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_OP, S_END} state_t;

  state_t          cs;
  logic [IW-1:0]   act;
  logic [IW-1:0]   last;
  logic [LW-1:0]   len_cnt;
  logic [NUM_CH-1:0] pend;

  // Per-channel descriptor slots
  logic            s_wr    [NUM_CH];
  logic [AW-1:0]   s_addr  [NUM_CH];
  logic [LW-1:0]   s_len   [NUM_CH];
  logic [2:0]      s_size  [NUM_CH];
  logic            s_burst [NUM_CH];

  logic [IW-1:0]   win;
  logic            win_vld;
  logic [IW-1:0]   cand;
  logic [DW-1:0]   din_sel;
  logic            lock_sel;
  logic [AW-1:0]   step;

`ifdef DMA_IF_MCH_TIMEOUT_EN
  localparam int unsigned TOW = ($clog2(TO_CYC + 1) > 8) ? $clog2(TO_CYC + 1) : 8;
  logic [TOW-1:0]  to_cnt;
`endif

  // Burst beat code chosen from the descriptor length
  function automatic logic [2:0] beat_code(input logic [LW-1:0] len);
    if (len == LW'(4))       beat_code = 3'b001;
    else if (len == LW'(8))  beat_code = 3'b010;
    else if (len == LW'(16)) beat_code = 3'b011;
    else                     beat_code = 3'b000;
  endfunction

  // Round-robin search starting just after the last served channel
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int k = 1; k <= int'(NUM_CH); k++) begin
      cand = IW'((int'(last) + k) % int'(NUM_CH));
      if (!win_vld && pend[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  // Active-channel muxes and status
  always_comb begin
    din_sel  = '0;
    lock_sel = 1'b0;
    ChBusy   = pend;
    DoutVld  = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (act == IW'(i)) begin
        din_sel  = Din[i*DW +: DW];
        lock_sel = DmaLock[i];
        if (cs != S_IDLE) ChBusy[i] = 1'b1;
        DoutVld[i] = RST_N & DataReady & ~Write;
      end
    end
  end

  assign step    = AW'(1) << Size;
  assign Request = (cs == S_OP);
  assign Lock    = lock_sel & (cs != S_IDLE);
  assign Busy    = |ChBusy;
  // Pass-through data paths are forced to 0 while reset is held
  assign DataIn  = RST_N ? din_sel : '0;
  assign Dout    = RST_N ? DataOut : '0;

  // Descriptor capture, arbitration load and beat-control FSM
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cs      <= S_IDLE;
      act     <= '0;
      last    <= '0;
      len_cnt <= '0;
      pend    <= '0;
      Addr    <= '0;
      Size    <= '0;
      Write   <= 1'b0;
      Burst   <= 1'b0;
      Beat    <= '0;
      ReadEn  <= '0;
      Done    <= '0;
      ErrDone <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        s_wr[i]    <= 1'b0;
        s_addr[i]  <= '0;
        s_len[i]   <= '0;
        s_size[i]  <= '0;
        s_burst[i] <= 1'b0;
      end
`ifdef DMA_IF_MCH_TIMEOUT_EN
      to_cnt  <= '0;
`endif
    end else begin
      ReadEn  <= '0;
      Done    <= '0;
      ErrDone <= '0;

      // A busy channel ignores Start
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (Start[i] && !ChBusy[i]) begin
          pend[i]    <= 1'b1;
          s_wr[i]    <= WR[i];
          s_addr[i]  <= WRAddr[i*AW +: AW];
          s_len[i]   <= WRLen[i*LW +: LW];
          s_size[i]  <= WRSize[i*3 +: 3];
          s_burst[i] <= WRBurst[i];
        end
      end

`ifdef DMA_IF_MCH_TIMEOUT_EN
      if (cs == S_END) to_cnt <= to_cnt + TOW'(1);
      else             to_cnt <= '0;
`endif

      case (cs)
        S_IDLE: begin
          if (win_vld) begin
            pend[win] <= 1'b0;
            act       <= win;
            last      <= win;
            len_cnt   <= s_len[win];
            Addr      <= s_addr[win];
            Size      <= s_size[win];
            Write     <= s_wr[win];
            Burst     <= s_burst[win];
            Beat      <= beat_code(s_len[win]);
            if (s_len[win] == '0) begin
              Done[win] <= 1'b1;
            end else begin
              cs <= S_OP;
              // Prefetch the first write word
              if (s_wr[win]) ReadEn[win] <= 1'b1;
            end
          end
        end
        S_OP: begin
          if (Error) begin
            cs           <= S_IDLE;
            Done[act]    <= 1'b1;
            ErrDone[act] <= 1'b1;
          end else if (Retry) begin
            len_cnt <= len_cnt + LW'(1);
            Addr    <= Addr - step;
          end else begin
            if (Okay && Write) ReadEn[act] <= 1'b1;
            if (Grant) begin
              len_cnt <= len_cnt - LW'(1);
              Addr    <= Addr + step;
              if (len_cnt == LW'(1)) cs <= S_END;
            end
          end
        end
        S_END: begin
          if (Error) begin
            cs           <= S_IDLE;
            Done[act]    <= 1'b1;
            ErrDone[act] <= 1'b1;
          end else if (Retry) begin
            cs      <= S_OP;
            len_cnt <= len_cnt + LW'(1);
            Addr    <= Addr - step;
          end else if (Okay) begin
            cs        <= S_IDLE;
            Done[act] <= 1'b1;
`ifdef DMA_IF_MCH_TIMEOUT_EN
          end else if (to_cnt == TOW'(TO_CYC)) begin
            cs           <= S_IDLE;
            Done[act]    <= 1'b1;
            ErrDone[act] <= 1'b1;
`endif
          end
        end
        default: cs <= S_IDLE;
      endcase
    end
  end

endmodule
